// File: rtl/dispatch_pkg.sv
// Shared types and constants for the instruction dispatch unit.
//   dispatch_state_t     : issue FSM state encoding
//   OPC_*                : default opcodes of the built-in execution IPs
//   DEFAULT_UNIT_OPCODES : default packed unit/opcode table (unit0 in the LSBs)
package dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_SETTLE  = 2'd3
    } dispatch_state_t;

    localparam logic [2:0] OPC_ALU   = 3'b100;
    localparam logic [2:0] OPC_MEMIO = 3'b010;
    localparam logic [2:0] OPC_PFCU  = 3'b110;
    localparam logic [2:0] OPC_UNIT3 = 3'b001;

    // Evaluates to 12'h394.
    localparam logic [11:0] DEFAULT_UNIT_OPCODES = {OPC_UNIT3, OPC_PFCU, OPC_MEMIO, OPC_ALU};

endpackage

// File: rtl/dispatch_watchdog.sv
// WAIT-state watchdog: counts enabled cycles since the last clear.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the count (asserted on the cycle an instruction issues)
//   count_en  : advance the count (high while waiting for a unit)
//   expired   : combinational; high on the TIMEOUT_CYCLES-th enabled cycle
module dispatch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Cycle counter; the owner leaves WAIT on expiry, so no saturation is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = count_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dispatch_unit.sv
// Instruction issue controller: routes each decoded instruction to one of
// NUM_UNITS execution units by opcode, waits for that unit's done, then
// requests the next instruction.
//   clk, rst      : clock, asynchronous active-high reset
//   inst          : instruction, opcode in inst[OPC_WIDTH-1:0]
//   inst_pres     : inst is valid
//   halt          : suppress new issues (does not abort an in-flight one)
//   unit_done     : per-unit completion level
//   unit_start    : one-hot, one-cycle issue pulse
//   unit_sel      : unit currently issued / busy
//   busy          : instruction in flight
//   rq_nxt_inst   : one-cycle next-instruction request
//   issued_count  : wrapping count of issue pulses
//   wdt_fault     : sticky watchdog fault
//   fault_unit    : unit that timed out
// Optional feature: define DISPATCH_WATCHDOG_EN to enable the WAIT watchdog;
// otherwise wdt_fault/fault_unit are tied low and WAIT holds indefinitely.
module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned INST_WIDTH     = 48,
    parameter int unsigned OPC_WIDTH      = 3,
    parameter logic [NUM_UNITS*OPC_WIDTH-1:0] UNIT_OPCODES =
        (NUM_UNITS*OPC_WIDTH)'(DEFAULT_UNIT_OPCODES),
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_pres,
    input  logic                  halt,
    input  logic [NUM_UNITS-1:0]  unit_done,
    output logic [NUM_UNITS-1:0]  unit_start,
    output logic [SEL_W-1:0]      unit_sel,
    output logic                  busy,
    output logic                  rq_nxt_inst,
    output logic [31:0]           issued_count,
    output logic                  wdt_fault,
    output logic [SEL_W-1:0]      fault_unit
);

    dispatch_state_t       state_q, state_d;
    logic                  hit;
    logic [SEL_W-1:0]      hit_idx;
    logic                  issue;
    logic                  timeout;
    logic                  wdt_expired;
    logic [NUM_UNITS-1:0]  start_d;
    logic [SEL_W-1:0]      unit_sel_q;
    logic                  busy_q;
    logic                  rq_q;
    logic [NUM_UNITS-1:0]  start_q;
    logic [31:0]           count_q;

    logic unused_inst;
    assign unused_inst = &{1'b0, inst[INST_WIDTH-1:OPC_WIDTH]};

    // Opcode lookup; scanning downward lets the lowest matching unit win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = int'(NUM_UNITS) - 1; k >= 0; k--) begin
            if (inst[OPC_WIDTH-1:0] == UNIT_OPCODES[k*OPC_WIDTH +: OPC_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        timeout = 1'b0;
        start_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (inst_pres && !halt) begin
                    if (hit) begin
                        issue   = 1'b1;
                        start_d = NUM_UNITS'(1) << hit_idx;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end
            end
            ST_WAIT: begin
                // done on the expiry cycle takes priority over the fault
                if (unit_done[unit_sel_q]) begin
                    state_d = ST_ADVANCE;
                end else if (wdt_expired) begin
                    timeout = 1'b1;
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: state_d = ST_SETTLE;
            ST_SETTLE:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            unit_sel_q <= '0;
            busy_q     <= 1'b0;
            rq_q       <= 1'b0;
            start_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_WAIT);
            rq_q    <= (state_d == ST_ADVANCE);
            start_q <= start_d;
            if (issue) begin
                unit_sel_q <= hit_idx;
                count_q    <= count_q + 32'd1;
            end
        end
    end

`ifdef DISPATCH_WATCHDOG_EN
    logic             fault_q;
    logic [SEL_W-1:0] fault_unit_q;

    dispatch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (issue),
        .count_en(state_q == ST_WAIT),
        .expired (wdt_expired)
    );

    // Sticky fault capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_unit_q <= '0;
        end else if (timeout) begin
            fault_q      <= 1'b1;
            fault_unit_q <= unit_sel_q;
        end
    end

    assign wdt_fault  = fault_q;
    assign fault_unit = fault_unit_q;
`else
    logic unused_cfg;
    assign unused_cfg  = &{1'b0, timeout, (TIMEOUT_CYCLES == 0)};
    assign wdt_expired = 1'b0;
    assign wdt_fault   = 1'b0;
    assign fault_unit  = '0;
`endif

    assign unit_start   = start_q;
    assign unit_sel     = unit_sel_q;
    assign busy         = busy_q;
    assign rq_nxt_inst  = rq_q;
    assign issued_count = count_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed self-checking bench for dispatch_unit (default opcode table,
// TIMEOUT_CYCLES=8 so the watchdog path is short when it is compiled in).
module tb_dispatch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] inst;
    logic        inst_pres;
    logic        halt;
    logic [3:0]  unit_done;
    logic [3:0]  unit_start;
    logic [1:0]  unit_sel;
    logic        busy;
    logic        rq_nxt_inst;
    logic [31:0] issued_count;
    logic        wdt_fault;
    logic [1:0]  fault_unit;

    int errors = 0;
    int checks = 0;

    dispatch_unit #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .inst_pres   (inst_pres),
        .halt        (halt),
        .unit_done   (unit_done),
        .unit_start  (unit_start),
        .unit_sel    (unit_sel),
        .busy        (busy),
        .rq_nxt_inst (rq_nxt_inst),
        .issued_count(issued_count),
        .wdt_fault   (wdt_fault),
        .fault_unit  (fault_unit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".start"}, 32'(unit_start), 32'h0);
        check({tag, ".sel"},   32'(unit_sel), 32'h0);
        check({tag, ".busy"},  32'(busy), 32'h0);
        check({tag, ".rq"},    32'(rq_nxt_inst), 32'h0);
        check({tag, ".count"}, issued_count, 32'h0);
        check({tag, ".fault"}, 32'(wdt_fault), 32'h0);
        check({tag, ".funit"}, 32'(fault_unit), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        rst = 1'b1; inst = '0; inst_pres = 1'b0; halt = 1'b0; unit_done = '0;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // ALU issue, one-cycle start, done three cycles later
        inst = 48'h0000_0000_0004; inst_pres = 1'b1;
        tick();
        check("alu.start", 32'(unit_start), 32'h1);
        check("alu.busy",  32'(busy), 32'h1);
        check("alu.sel",   32'(unit_sel), 32'h0);
        check("alu.count", issued_count, 32'd1);
        inst_pres = 1'b0;
        tick();
        check("alu.start_once", 32'(unit_start), 32'h0);
        check("alu.busy2", 32'(busy), 32'h1);
        tick();
        unit_done = 4'b0001;
        tick();
        check("alu.rq",    32'(rq_nxt_inst), 32'h1);
        check("alu.idle",  32'(busy), 32'h0);
        unit_done = 4'b0000;
        tick();
        check("alu.rq_once", 32'(rq_nxt_inst), 32'h0);
        // new instruction during SETTLE: earliest issue is one cycle later
        inst = 48'h0000_0000_0002; inst_pres = 1'b1;
        tick();
        check("settle.no_issue", 32'(unit_start), 32'h0);
        tick();
        check("memio.start", 32'(unit_start), 32'h2);
        check("memio.sel",   32'(unit_sel), 32'h1);
        check("memio.count", issued_count, 32'd2);
        inst_pres = 1'b0;
        unit_done = 4'b0010;
        tick();
        check("memio.rq", 32'(rq_nxt_inst), 32'h1);
        unit_done = 4'b0000;
        tick(); tick();

        // unknown opcode skips straight to the next-instruction request
        inst = 48'h0000_0000_0000; inst_pres = 1'b1;
        tick();
        check("unk.rq",    32'(rq_nxt_inst), 32'h1);
        check("unk.start", 32'(unit_start), 32'h0);
        check("unk.busy",  32'(busy), 32'h0);
        check("unk.count", issued_count, 32'd2);
        inst_pres = 1'b0;
        tick(); tick();

        // PFCU issue; done from other units is ignored
        inst = 48'h0000_0000_0006; inst_pres = 1'b1;
        tick();
        check("pfcu.start", 32'(unit_start), 32'h4);
        check("pfcu.sel",   32'(unit_sel), 32'h2);
        check("pfcu.count", issued_count, 32'd3);
        inst_pres = 1'b0;
        unit_done = 4'b0001;
        tick();
        check("pfcu.ign0.busy", 32'(busy), 32'h1);
        unit_done = 4'b0010;
        tick();
        check("pfcu.ign1.busy", 32'(busy), 32'h1);
        check("pfcu.ign1.rq",   32'(rq_nxt_inst), 32'h0);
        unit_done = 4'b0100;
        tick();
        check("pfcu.rq", 32'(rq_nxt_inst), 32'h1);
        unit_done = 4'b0000;
        tick(); tick();

        // halt with a valid instruction blocks issue for 10 cycles
        halt = 1'b1; inst = 48'h0000_0000_0001; inst_pres = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt.no_start", 32'({unit_start, busy}), 32'h0);
        end
        check("halt.count", issued_count, 32'd3);
        halt = 1'b0;
        tick();
        check("unhalt.start", 32'(unit_start), 32'h8);
        check("unhalt.sel",   32'(unit_sel), 32'h3);
        check("unhalt.count", issued_count, 32'd4);
        // halt during WAIT does not abort, but blocks the next issue
        inst = 48'h0000_0000_0004; halt = 1'b1;
        tick();
        check("halt_wait.busy", 32'(busy), 32'h1);
        unit_done = 4'b1000;
        tick();
        check("halt_wait.rq", 32'(rq_nxt_inst), 32'h1);
        unit_done = 4'b0000;
        tick(); tick(); tick();
        check("halt_idle.no_start", 32'(unit_start), 32'h0);
        halt = 1'b0;
        tick();
        check("rehalt.start", 32'(unit_start), 32'h1);
        check("rehalt.count", issued_count, 32'd5);
        inst_pres = 1'b0;
        unit_done = 4'b0001;
        tick();
        unit_done = 4'b0000;
        tick(); tick();

        // unit1 never completes
        inst = 48'h0000_0000_0002; inst_pres = 1'b1;
        tick();
        check("wdt.start", 32'(unit_start), 32'h2);
        check("wdt.count", issued_count, 32'd6);
        inst_pres = 1'b0;
`ifdef DISPATCH_WATCHDOG_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wdt.waiting", 32'({wdt_fault, busy}), 32'h1);
        end
        tick();
        check("wdt.fault", 32'(wdt_fault), 32'h1);
        check("wdt.funit", 32'(fault_unit), 32'h1);
        check("wdt.rq",    32'(rq_nxt_inst), 32'h1);
        check("wdt.busy",  32'(busy), 32'h0);
        tick(); tick(); tick();
        check("wdt.sticky", 32'(wdt_fault), 32'h1);
`else
        for (int i = 0; i < 20; i++) tick();
        check("nowdt.busy",  32'(busy), 32'h1);
        check("nowdt.rq",    32'(rq_nxt_inst), 32'h0);
        check("nowdt.fault", 32'(wdt_fault), 32'h0);
        unit_done = 4'b0010;
        tick();
        check("nowdt.rq_done", 32'(rq_nxt_inst), 32'h1);
        unit_done = 4'b0000;
        tick(); tick();
`endif

        // asynchronous reset mid-WAIT
        inst = 48'h0000_0000_0004; inst_pres = 1'b1;
        tick();
        check("rstw.start", 32'(unit_start), 32'h1);
        check("rstw.count", issued_count, 32'd7);
        inst_pres = 1'b0;
        tick();
        check("rstw.busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        tick(); tick();
        check("rst_hold.rq", 32'(rq_nxt_inst), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst.rq",   32'(rq_nxt_inst), 32'h0);
        check("post_rst.busy", 32'(busy), 32'h0);
        inst = 48'h0000_0000_0006; inst_pres = 1'b1;
        tick();
        check("post_rst.start", 32'(unit_start), 32'h4);
        check("post_rst.count", issued_count, 32'd1);
        inst_pres = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
